axi4l_reg_initiator: RTL and testbench
======================================

// Module: axi4l_reg_initiator
// PURPOSE
// - AXI4-Lite initiator (master) used by local logic to read/write a single 32-bit word in a register bank behind an AXI4-Lite slave.
// - Converts a simple command/response port into AW/W/B and AR/R transactions.
// - Only one transaction is outstanding at a time. Intended for test harnesses and embedded sequencers that drive generated register banks.
// PARAMETERS
// - ADDR_W   8       byte-address width of awaddr/araddr/cmd_addr
// - PROT     3'b000  constant value driven on awprot/arprot
// - TIMEOUT  255     cycles allowed per transaction; used only with AXI4L_INIT_TIMEOUT_EN
// PORTS
// - aclk             in   1       clock
// - areset_n         in   1       reset: synchronous, active-low
// - cmd_valid        in   1       command request
// - cmd_ready        out  1       high only in IDLE
// - cmd_we           in   1       1=write, 0=read
// - cmd_addr         in   ADDR_W  byte address
// - cmd_wdata        in   32      write data
// - cmd_wstrb        in   4       write byte strobes
// - rsp_valid        out  1       one-cycle completion pulse; no backpressure
// - rsp_rdata        out  32      read data; 0 for writes and errors
// - rsp_err          out  1       1 when the response code is SLVERR, DECERR, or a timeout
// - awvalid, wvalid  out  1       write address / write data valid
// - awready, wready  in   1       write address / write data ready
// - awaddr, araddr   out  ADDR_W  registered copy of cmd_addr
// - awprot, arprot   out  3       driven as PROT
// - wdata / wstrb    out  32 / 4 registered copies of cmd_wdata / cmd_wstrb
// - bvalid, bresp    in   1 / 2   write response
// - bready           out  1       high only in WRESP
// - arvalid          out  1       read address valid
// - arready          in   1       read address ready
// - rvalid, rdata    in   1 / 32  read data
// - rresp            in   2       read response code
// - rready           out  1       high only in RDATA
// BEHAVIOUR
// - Reset values: every output is 0 (valids, readys, cmd_ready, rsp_*, addr/data regs); the FSM goes to IDLE. cmd_ready rises the first cycle after release.
// - FSM states: IDLE, WRITE, WRESP, READ, RDATA.
// - IDLE: a cmd_valid&cmd_ready handshake registers addr/wdata/wstrb/we; next state is WRITE (we=1) or READ (we=0).
// - WRITE: awvalid and wvalid both rise in the cycle after the command is accepted.
//   - Each valid drops independently in the cycle after its own ready is sampled high.
//   - Payloads stay stable while valid is high.
//   - If both readys are high in the same cycle, both channels complete together.
//   - Once both channels are done, the FSM moves to WRESP.
// - WRESP: bready=1. When bvalid is sampled: rsp_valid pulses in the next cycle, rsp_err=bresp[1], rsp_rdata=0, state returns to IDLE.
// - READ: arvalid is held until arready is sampled, then the FSM moves to RDATA.
// - RDATA: rready=1. When rvalid is sampled: rsp_rdata=rdata (0 if rresp[1]), rsp_err=rresp[1], rsp_valid pulses in the next cycle, state returns to IDLE.
// - bvalid/rvalid arriving outside WRESP/RDATA are ignored (their ready is low).
// - rsp_valid never coincides with cmd_ready. The earliest new command is accepted the cycle after rsp_valid.
// - Reset mid-transaction: all valid/ready signals drop in the cycle following the reset edge, no rsp_valid is produced, and any late slave response is ignored.
// CONFIGURATION
// - Macro AXI4L_INIT_TIMEOUT_EN defined:
//   - An 8..16-bit counter clears on leaving IDLE and increments in every non-IDLE cycle.
//   - When it reaches TIMEOUT: all valids/readys drop, rsp_valid pulses with rsp_err=1 and rsp_rdata=0, state returns to IDLE.
//   - If completion and timeout occur in the same cycle, completion wins.
// - Macro undefined: no counter is built, TIMEOUT is ignored, and the block waits indefinitely.
// STRUCTURE
// - Shared package axi4l_pkg: resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11; typedef enum logic[2:0] axi4l_init_state_t.
// - Single module, no sub-module; the timeout counter is inline under the ifdef.
// TESTING
// - Write 0x04 / 0xDEADBEEF / strb 4'hF to an always-ready slave with bresp=00 -> one AW and one W beat carrying awaddr=0x04; then rsp_valid=1, rsp_err=0.
// - awready held low for 3 cycles, wready=1 immediately -> wvalid high exactly 1 cycle; awvalid/awaddr stable for 4 cycles; exactly one rsp_valid.
// - Read 0x00; slave returns rvalid with 0x12345678 and rresp=00 after 4 cycles -> rsp_rdata=0x12345678, rsp_err=0; cmd_ready re-asserts the cycle after the pulse.
// - Write answered with bresp=2'b10; read answered with rresp=2'b11 -> rsp_err=1 both times; rsp_rdata=0 on the read.
// - areset_n low for 1 cycle while awvalid=1 -> next cycle awvalid=wvalid=0, cmd_ready=0, no rsp_valid; cmd_ready=1 one cycle after release.
// - With AXI4L_INIT_TIMEOUT_EN, TIMEOUT=16, and a slave that never sets awready -> rsp_valid with rsp_err=1 after 16 non-IDLE cycles. Without the macro, there is no rsp_valid after 1000 cycles.

Source files
------------

// File: rtl/axi4l_pkg.sv
// ---------------------------------------------------------------------------
// axi4l_pkg
// Shared AXI4-Lite definitions for the register initiator:
//   - response codes OKAY / EXOKAY / SLVERR / DECERR
//   - axi4l_init_state_t : initiator FSM state encoding
//   - resp_is_err()      : true for SLVERR and DECERR
// ---------------------------------------------------------------------------
package axi4l_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4
    } axi4l_init_state_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/axi4l_reg_initiator.sv
// ---------------------------------------------------------------------------
// axi4l_reg_initiator
// AXI4-Lite master that turns a simple command/response port into single
// AW/W/B or AR/R transactions, one outstanding at a time.
//
// Ports
//   aclk, areset_n           clock, synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_we/addr/wdata/wstrb  command payload (we=1 write, we=0 read)
//   rsp_valid                one-cycle completion pulse, no backpressure
//   rsp_rdata/rsp_err        read data (0 for writes/errors), error flag
//   aw*, w*, b*              AXI4-Lite write channels
//   ar*, r*                  AXI4-Lite read channels
//
// Optional build macro
//   AXI4L_INIT_TIMEOUT_EN : abort a transaction after TIMEOUT non-IDLE
//                           cycles with rsp_err=1. Without it the block
//                           waits for the slave indefinitely.
// ---------------------------------------------------------------------------
module axi4l_reg_initiator
    import axi4l_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter logic [2:0]  PROT    = 3'b000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              wvalid,
    input  logic              wready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    input  logic              bvalid,
    input  logic [1:0]        bresp,
    output logic              bready,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    input  logic              rvalid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    output logic              rready
);

    axi4l_init_state_t state_q, state_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [3:0]        wstrb_q,     wstrb_d;
    logic              awvalid_q,   awvalid_d;
    logic              wvalid_q,    wvalid_d;
    logic              bready_q,    bready_d;
    logic              arvalid_q,   arvalid_d;
    logic              rready_q,    rready_d;
    logic              timeout_hit;

`ifdef AXI4L_INIT_TIMEOUT_EN
    localparam int unsigned TMO_BITS = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W    = (TMO_BITS < 8)  ? 8  :
                                       (TMO_BITS > 16) ? 16 : TMO_BITS;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero while idle so the first busy cycle of every transaction
    // starts counting from zero.
    always_comb begin
        tmo_cnt_d = (state_q == ST_IDLE) ? '0 : tmo_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Fires during the TIMEOUT-th busy cycle; the abort lands on that edge.
    assign timeout_hit = (state_q != ST_IDLE) &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Every output is a flop, so its next value is derived from the next
    // state. cmd_ready is suppressed while the response pulse is out so a
    // new command is only taken the cycle after rsp_valid.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_we) begin
                        state_d   = ST_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_READ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                // AW and W retire independently; move on once both are gone.
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q  && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (bvalid && bready_q) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = resp_is_err(bresp);
                    rsp_rdata_d = '0;
                end
            end
            ST_READ: begin
                arvalid_d = arvalid_q && !arready;
                if (!arvalid_d) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (rvalid && rready_q) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = resp_is_err(rresp);
                    rsp_rdata_d = resp_is_err(rresp) ? 32'h0 : rdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A real completion in the same cycle takes precedence over abort.
        if (timeout_hit && !rsp_valid_d) begin
            state_d     = ST_IDLE;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end

        cmd_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
        bready_d    = (state_d == ST_WRESP);
        rready_d    = (state_d == ST_RDATA);
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = addr_q;
    assign awprot    = PROT;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign bready    = bready_q;
    assign arvalid   = arvalid_q;
    assign araddr    = addr_q;
    assign arprot    = PROT;
    assign rready    = rready_q;

endmodule

// File: tb/tb_axi4l_reg_initiator.sv
// ---------------------------------------------------------------------------
// tb_axi4l_reg_initiator
// Self-checking bench for axi4l_reg_initiator. A cycle-level slave with a
// 16-word register bank answers the DUT; an independent word array holds
// the expected bank contents computed from the issued commands.
// Honours AXI4L_INIT_TIMEOUT_EN to pick the abort or wait-forever check.
// ---------------------------------------------------------------------------
module tb_axi4l_reg_initiator;

    localparam int TMO = 16;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        awvalid, awready, wvalid, wready;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] slaveMem [16];
    logic [31:0] expMem   [16];

    always #5 aclk = ~aclk;

    axi4l_reg_initiator #(.ADDR_W(8), .PROT(3'b000), .TIMEOUT(TMO)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
    );

    function automatic logic [31:0] merge(input logic [31:0] oldW, input logic [31:0] newW,
                                          input logic [3:0] strb);
        logic [31:0] r = oldW;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = newW[8*b +: 8];
        return r;
    endfunction

    // Issues one command and plays the slave side at each falling edge.
    // Called and returns at a falling edge.
    task automatic run_txn(input logic we, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int awDly, input int wDly,
                           input int bDly, input int arDly, input int rDly,
                           input logic [1:0] resp,
                           output int rspCnt, output logic gotErr, output logic [31:0] gotRdata,
                           output int awCycles, output int wCycles, output int arCycles,
                           output int overlapCnt, output logic payloadOk,
                           output logic readyAfter);
        int cyc = 0, bWait = 0, rWait = 0, tail = 0;
        bit awDone = 0, wDone = 0, arDone = 0, bFired = 0, rFired = 0, done = 0;
        logic [7:0]  capAw = '0, capAr = '0;
        logic [31:0] capW  = '0;
        logic [3:0]  capS  = '0;
        rspCnt = 0; gotErr = 1'bx; gotRdata = 'x; awCycles = 0; wCycles = 0;
        arCycles = 0; overlapCnt = 0; payloadOk = 1'b1; readyAfter = 1'b0;
        while (cmd_ready !== 1'b1 && cyc < 20) begin @(negedge aclk); cyc++; end
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(negedge aclk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            if (rsp_valid === 1'b1) begin
                rspCnt++; gotErr = rsp_err; gotRdata = rsp_rdata;
                if (cmd_ready !== 1'b0) overlapCnt++;
            end
            if (awvalid === 1'b1) begin
                awCycles++;
                if (awaddr !== addr || awprot !== 3'b000) payloadOk = 1'b0;
            end
            if (wvalid === 1'b1) begin
                wCycles++;
                if (wdata !== data || wstrb !== strb) payloadOk = 1'b0;
            end
            if (arvalid === 1'b1) begin
                arCycles++;
                if (araddr !== addr || arprot !== 3'b000) payloadOk = 1'b0;
            end
            if (bFired) bvalid = 1'b0;
            else if (awDone && wDone) begin
                bWait++;
                if (bWait > bDly) begin
                    bvalid = 1'b1; bresp = resp;
                    if (bready === 1'b1) begin
                        bFired = 1;
                        if (!resp[1]) slaveMem[capAw[5:2]] = merge(slaveMem[capAw[5:2]], capW, capS);
                    end
                end
            end
            if (rFired) rvalid = 1'b0;
            else if (arDone) begin
                rWait++;
                if (rWait > rDly) begin
                    rvalid = 1'b1; rresp = resp; rdata = slaveMem[capAr[5:2]];
                    if (rready === 1'b1) rFired = 1;
                end
            end
            awready = (awvalid === 1'b1) && (awCycles > awDly);
            if (awready) begin awDone = 1; capAw = awaddr; end
            wready = (wvalid === 1'b1) && (wCycles > wDly);
            if (wready) begin wDone = 1; capW = wdata; capS = wstrb; end
            arready = (arvalid === 1'b1) && (arCycles > arDly);
            if (arready) begin arDone = 1; capAr = araddr; end
            if (rspCnt > 0) begin
                tail++;
                if (tail == 2) readyAfter = (cmd_ready === 1'b1) && (rsp_valid === 1'b0);
            end
            if (tail >= 3) done = 1;
            @(negedge aclk);
            cyc++;
        end
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        repeat (3) @(negedge aclk);
        nCompared++;
        if ({cmd_ready, rsp_valid, rsp_err, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL reset_ctrl: got %b required 00000000",
                     {cmd_ready, rsp_valid, rsp_err, awvalid, wvalid, bready, arvalid, rready});
        end
        nCompared++;
        if ({rsp_rdata, awaddr, araddr, wdata, wstrb} !== 84'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_data: got %h required 0", {rsp_rdata, awaddr, araddr, wdata, wstrb});
        end
        areset_n = 1'b1;
        @(negedge aclk);
        nCompared++;
        if (cmd_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_release_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_basic_write();
        int rc, awc, wc, arc, ov; logic e, pOk, rdy; logic [31:0] rd;
        run_txn(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00,
                rc, e, rd, awc, wc, arc, ov, pOk, rdy);
        expMem[1] = 32'hDEADBEEF;
        nCompared++; if (rc !== 1) begin nMismatched++; $display("[TB] FAIL basic_wr_rsp_count: got %0d required 1", rc); end
        nCompared++; if (e !== 1'b0 || rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL basic_wr_rsp: got err=%b rdata=%h required err=0 rdata=0", e, rd); end
        nCompared++; if (awc !== 1 || wc !== 1) begin nMismatched++; $display("[TB] FAIL basic_wr_beats: got aw=%0d w=%0d required 1/1", awc, wc); end
        nCompared++; if (pOk !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_wr_payload: got %b required 1", pOk); end
        nCompared++; if (ov !== 0 || rdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_wr_ready: got overlap=%0d readyAfter=%b required 0/1", ov, rdy); end
    endtask

    task automatic test_aw_stall();
        int rc, awc, wc, arc, ov; logic e, pOk, rdy; logic [31:0] rd;
        run_txn(1'b1, 8'h08, 32'h0BAD_F00D, 4'h5, 3, 0, 1, 0, 0, 2'b00,
                rc, e, rd, awc, wc, arc, ov, pOk, rdy);
        expMem[2] = merge(expMem[2], 32'h0BAD_F00D, 4'h5);
        nCompared++; if (wc !== 1) begin nMismatched++; $display("[TB] FAIL stall_w_cycles: got %0d required 1", wc); end
        nCompared++; if (awc !== 4) begin nMismatched++; $display("[TB] FAIL stall_aw_cycles: got %0d required 4", awc); end
        nCompared++; if (pOk !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_payload_stable: got %b required 1", pOk); end
        nCompared++; if (rc !== 1 || e !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_rsp: got count=%0d err=%b required 1/0", rc, e); end
    endtask

    task automatic test_read_delay();
        int rc, awc, wc, arc, ov; logic e, pOk, rdy; logic [31:0] rd;
        slaveMem[0] = 32'h12345678; expMem[0] = 32'h12345678;
        run_txn(1'b0, 8'h00, 32'h0, 4'h0, 0, 0, 0, 0, 4, 2'b00,
                rc, e, rd, awc, wc, arc, ov, pOk, rdy);
        nCompared++; if (rc !== 1 || rd !== 32'h12345678 || e !== 1'b0) begin nMismatched++; $display("[TB] FAIL read_rsp: got count=%0d rdata=%h err=%b required 1/12345678/0", rc, rd, e); end
        nCompared++; if (arc !== 1 || awc !== 0 || wc !== 0) begin nMismatched++; $display("[TB] FAIL read_beats: got ar=%0d aw=%0d w=%0d required 1/0/0", arc, awc, wc); end
        nCompared++; if (ov !== 0 || rdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL read_ready_after: got overlap=%0d readyAfter=%b required 0/1", ov, rdy); end
    endtask

    task automatic test_errors();
        int rc, awc, wc, arc, ov; logic e, pOk, rdy; logic [31:0] rd;
        run_txn(1'b1, 8'h0C, 32'hCAFE_0001, 4'hF, 0, 1, 2, 0, 0, 2'b10,
                rc, e, rd, awc, wc, arc, ov, pOk, rdy);
        nCompared++; if (rc !== 1 || e !== 1'b1 || rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL err_write: got count=%0d err=%b rdata=%h required 1/1/0", rc, e, rd); end
        run_txn(1'b0, 8'h04, 32'h0, 4'h0, 0, 0, 0, 1, 1, 2'b11,
                rc, e, rd, awc, wc, arc, ov, pOk, rdy);
        nCompared++; if (rc !== 1 || e !== 1'b1 || rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL err_read: got count=%0d err=%b rdata=%h required 1/1/0", rc, e, rd); end
    endtask

    task automatic test_mid_reset();
        int rsps = 0, cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 20) begin @(negedge aclk); cyc++; end
        awready = 0; wready = 0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'h5555AAAA; cmd_wstrb = 4'hF;
        @(negedge aclk);
        cmd_valid = 1'b0;
        nCompared++; if (awvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst_aw_started: got %b required 1", awvalid); end
        areset_n = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        @(negedge aclk);
        nCompared++;
        if ({awvalid, wvalid, cmd_ready, rsp_valid, bready} !== 5'b0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_drop: got %b required 00000", {awvalid, wvalid, cmd_ready, rsp_valid, bready});
        end
        areset_n = 1'b1;
        @(negedge aclk);
        nCompared++; if (cmd_ready !== 1'b1 || bready !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_release: got ready=%b bready=%b required 1/0", cmd_ready, bready); end
        if (rsp_valid === 1'b1) rsps++;
        bvalid = 1'b0;
        repeat (4) begin @(negedge aclk); if (rsp_valid === 1'b1) rsps++; end
        nCompared++; if (rsps !== 0) begin nMismatched++; $display("[TB] FAIL midrst_no_rsp: got %0d pulses required 0", rsps); end
    endtask

    task automatic test_random();
        int rc, awc, wc, arc, ov, awD, wD, bD, arD, rD, sel;
        logic e, pOk, rdy, we; logic [31:0] rd, data, expRd; logic [3:0] strb, idx; logic [1:0] resp;
        for (int t = 0; t < 24; t++) begin
            we = 1'($urandom_range(0, 1)); idx = 4'($urandom_range(0, 15));
            data = $urandom; strb = 4'($urandom_range(0, 15));
            awD = $urandom_range(0, 3); wD = $urandom_range(0, 3); bD = $urandom_range(0, 3);
            arD = $urandom_range(0, 3); rD = $urandom_range(0, 3); sel = $urandom_range(0, 7);
            resp = (sel < 5) ? 2'b00 : (sel == 5) ? 2'b01 : (sel == 6) ? 2'b10 : 2'b11;
            run_txn(we, {2'b00, idx, 2'b00}, data, strb, awD, wD, bD, arD, rD, resp,
                    rc, e, rd, awc, wc, arc, ov, pOk, rdy);
            expRd = (we || resp[1]) ? 32'h0 : expMem[idx];
            if (we && !resp[1]) expMem[idx] = merge(expMem[idx], data, strb);
            nCompared++; if (rc !== 1 || e !== resp[1]) begin nMismatched++; $display("[TB] FAIL rnd%0d_rsp: got count=%0d err=%b required 1/%b", t, rc, e, resp[1]); end
            nCompared++; if (rd !== expRd) begin nMismatched++; $display("[TB] FAIL rnd%0d_rdata: got %h required %h", t, rd, expRd); end
            nCompared++; if (pOk !== 1'b1 || ov !== 0 || rdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL rnd%0d_proto: got payloadOk=%b overlap=%0d readyAfter=%b required 1/0/1", t, pOk, ov, rdy); end
            nCompared++;
            if (we ? (awc !== awD + 1 || wc !== wD + 1 || arc !== 0) : (arc !== arD + 1 || awc !== 0 || wc !== 0)) begin
                nMismatched++;
                $display("[TB] FAIL rnd%0d_beats: got aw=%0d w=%0d ar=%0d required delays aw=%0d w=%0d ar=%0d we=%b", t, awc, wc, arc, awD, wD, arD, we);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc = 0, rsps = 0, firstRsp = 0; logic e = 1'b0, awAt = 1'b1, rdyNext = 1'b0; logic [31:0] rd = 'x;
        while (cmd_ready !== 1'b1 && cyc < 20) begin @(negedge aclk); cyc++; end
        awready = 1'b0; wready = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h14; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
        @(negedge aclk);
        cmd_valid = 1'b0;
`ifdef AXI4L_INIT_TIMEOUT_EN
        for (int k = 1; k <= 40; k++) begin
            if (firstRsp != 0 && k == firstRsp + 1) rdyNext = cmd_ready;
            if (rsp_valid === 1'b1) begin
                rsps++;
                if (firstRsp == 0) begin firstRsp = k; e = rsp_err; rd = rsp_rdata; awAt = awvalid; end
            end
            @(negedge aclk);
        end
        nCompared++; if (firstRsp !== TMO + 1 || rsps !== 1) begin nMismatched++; $display("[TB] FAIL timeout_pulse: got cycle=%0d count=%0d required %0d/1", firstRsp, rsps, TMO + 1); end
        nCompared++; if (e !== 1'b1 || rd !== 32'h0 || awAt !== 1'b0) begin nMismatched++; $display("[TB] FAIL timeout_rsp: got err=%b rdata=%h awvalid=%b required 1/0/0", e, rd, awAt); end
        nCompared++; if (rdyNext !== 1'b1) begin nMismatched++; $display("[TB] FAIL timeout_ready_after: got %b required 1", rdyNext); end
`else
        for (int k = 1; k <= 1000; k++) begin
            if (rsp_valid === 1'b1) rsps++;
            @(negedge aclk);
        end
        nCompared++; if (rsps !== 0) begin nMismatched++; $display("[TB] FAIL no_timeout_rsp: got %0d pulses required 0", rsps); end
        nCompared++; if (awvalid !== 1'b1 || cmd_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL no_timeout_waiting: got awvalid=%b ready=%b required 1/0", awvalid, cmd_ready); end
`endif
        e = rsp_err; rd = 32'h0;
        wready = 1'b0;
        areset_n = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
    endtask

    initial begin
        areset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; arready = 1'b0; rvalid = 1'b0;
        rdata = '0; rresp = 2'b00;
        for (int i = 0; i < 16; i++) begin slaveMem[i] = $urandom; expMem[i] = slaveMem[i]; end
        $display("[TB] starting axi4l_reg_initiator bench");
        test_reset();
        test_basic_write();
        test_aw_stall();
        test_read_delay();
        test_errors();
        test_mid_reset();
        test_random();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
